mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter_chk.sv | 17 +
 rtl/mem_arbiter_rr_arb2.sv | 46 ++++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants, FSM state encoding and small helpers for the two-port
// memory arbiter.
package mem_ctrl_pkg;

  localparam int MEM_WIDTH = 8;
  localparam int MEM_DEPTH = 2;
  localparam int WORD_NUMB = 2 ** MEM_DEPTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshake and shared memory port bundle; the slave modport is the
// arbiter's view, the master modport the requester/memory side.
interface mem_arbiter_if
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_WIDTH = mem_ctrl_pkg::MEM_WIDTH,
  parameter int MEM_DEPTH = mem_ctrl_pkg::MEM_DEPTH
);

  logic [1:0]           req_valid;
  logic [1:0]           req_write;
  logic [MEM_DEPTH-1:0] req_addr0;
  logic [MEM_DEPTH-1:0] req_addr1;
  logic [MEM_WIDTH-1:0] req_wdata0;
  logic [MEM_WIDTH-1:0] req_wdata1;
  logic [1:0]           req_ready;
  logic [1:0]           rsp_valid;
  logic [MEM_WIDTH-1:0] rsp_rdata;
  logic [MEM_DEPTH-1:0] mem_addr;
  logic                 mem_write_en;
  logic                 mem_read_en;
  logic [MEM_WIDTH-1:0] mem_write_in;
  logic [MEM_WIDTH-1:0] mem_read_out;

  modport slave (
    input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  mem_read_out,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_addr, mem_write_en, mem_read_en, mem_write_in
  );

  modport master (
    output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output mem_read_out,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_addr, mem_write_en, mem_read_en, mem_write_in
  );

endinterface

// File: rtl/mem_arbiter_chk.sv
// Protocol checker for the arbiter outputs; instantiated alongside the design.
module mem_arbiter_chk (
  input logic       clk,
  input logic       rst,
  input logic [1:0] req_ready,
  input logic [1:0] rsp_valid,
  input logic       mem_write_en,
  input logic       mem_read_en
);

  a_en_excl: assert property (@(posedge clk) !(mem_write_en && mem_read_en));
  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));
  a_rsp_onehot: assert property (@(posedge clk) $onehot0(rsp_valid));
  a_quiet_in_reset: assert property (@(posedge clk)
    rst |-> (req_ready == 2'b00) && (rsp_valid == 2'b00));

endmodule

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the requester named by the pointer, and each grant hands priority away.
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_r;
  logic ptr_nxt_s;

  // Combinational grant from the request vector and priority pointer
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = id_to_onehot(ptr_r);
      default: grant = 2'b00;
    endcase
  end

  // Pointer moves to the requester that lost, only when a grant is taken
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (advance && (grant != 2'b00)) begin
      ptr_nxt_s = ~grant[1];
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one single-cycle memory port: accept in
// IDLE, drive the memory for one ACCESS cycle, then pulse the response.
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_WIDTH = mem_ctrl_pkg::MEM_WIDTH,
  parameter int MEM_DEPTH = mem_ctrl_pkg::MEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [1:0]           grant_s;
  logic [1:0]           ready_s;
  logic                 transfer_s;

  logic                 id_r;
  logic                 op_r;
  logic [MEM_DEPTH-1:0] addr_r;
  logic [MEM_WIDTH-1:0] wdata_r;
  logic                 wr_en_r;
  logic                 rd_en_r;
  logic [1:0]           rsp_valid_r;
  logic [MEM_WIDTH-1:0] rdata_r;

  logic                 id_nxt_s;
  logic                 op_nxt_s;
  logic [MEM_DEPTH-1:0] addr_nxt_s;
  logic [MEM_WIDTH-1:0] wdata_nxt_s;
  logic                 wr_en_nxt_s;
  logic                 rd_en_nxt_s;
  logic [1:0]           rsp_valid_nxt_s;
  logic [MEM_WIDTH-1:0] rdata_nxt_s;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (transfer_s),
    .grant   (grant_s)
  );

  // Ready is offered only in IDLE and never while reset is applied
  always_comb begin
    if (!rst && (state_r == IDLE)) begin
      ready_s = grant_s;
    end else begin
      ready_s = 2'b00;
    end
  end

  assign transfer_s = |(ready_s & bus.req_valid);

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (transfer_s) begin
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS:  state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath next values; enables and the response strobe are one-cycle pulses
  always_comb begin
    id_nxt_s        = id_r;
    op_nxt_s        = op_r;
    addr_nxt_s      = addr_r;
    wdata_nxt_s     = wdata_r;
    wr_en_nxt_s     = 1'b0;
    rd_en_nxt_s     = 1'b0;
    rsp_valid_nxt_s = 2'b00;
    rdata_nxt_s     = rdata_r;
    case (state_r)
      IDLE: begin
        if (transfer_s) begin
          id_nxt_s    = grant_s[1];
          op_nxt_s    = bus.req_write[grant_s[1]];
          addr_nxt_s  = grant_s[1] ? bus.req_addr1 : bus.req_addr0;
          wdata_nxt_s = grant_s[1] ? bus.req_wdata1 : bus.req_wdata0;
          wr_en_nxt_s = bus.req_write[grant_s[1]];
          rd_en_nxt_s = ~bus.req_write[grant_s[1]];
        end else begin
          wr_en_nxt_s = 1'b0;
          rd_en_nxt_s = 1'b0;
        end
      end
      ACCESS: begin
        rsp_valid_nxt_s = id_to_onehot(id_r);
        if (op_r) begin
          rdata_nxt_s = {MEM_WIDTH{1'b0}};
        end else begin
          rdata_nxt_s = bus.mem_read_out;
        end
      end
      RESP: begin
        rsp_valid_nxt_s = 2'b00;
      end
      default: begin
        rsp_valid_nxt_s = 2'b00;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latched request fields and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      id_r        <= 1'b0;
      op_r        <= 1'b0;
      addr_r      <= {MEM_DEPTH{1'b0}};
      wdata_r     <= {MEM_WIDTH{1'b0}};
      wr_en_r     <= 1'b0;
      rd_en_r     <= 1'b0;
      rsp_valid_r <= 2'b00;
      rdata_r     <= {MEM_WIDTH{1'b0}};
    end else begin
      id_r        <= id_nxt_s;
      op_r        <= op_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      wr_en_r     <= wr_en_nxt_s;
      rd_en_r     <= rd_en_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rdata_r     <= rdata_nxt_s;
    end
  end

  // A reset landing on the RESP cycle must still suppress the pulse
  always_comb begin
    if (rst) begin
      bus.rsp_valid = 2'b00;
    end else begin
      bus.rsp_valid = rsp_valid_r;
    end
  end

  assign bus.req_ready    = ready_s;
  assign bus.rsp_rdata    = rdata_r;
  assign bus.mem_addr     = addr_r;
  assign bus.mem_write_in = wdata_r;
  assign bus.mem_write_en = wr_en_r;
  assign bus.mem_read_en  = rd_en_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus
// hand-written sequences, with a response scoreboard and a memory model.
module tb_mem_arbiter;
  import mem_ctrl_pkg::*;

  typedef struct {
    logic [1:0]           valid;
    logic [1:0]           write;
    logic [MEM_DEPTH-1:0] a0;
    logic [MEM_DEPTH-1:0] a1;
    logic [MEM_WIDTH-1:0] d0;
    logic [MEM_WIDTH-1:0] d1;
    logic [1:0]           ready;
  } vec_t;

  typedef struct {
    logic                 id;
    logic [MEM_WIDTH-1:0] rdata;
    int                   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t                 sb[$];
  vec_t                 vt[12];
  logic [MEM_WIDTH-1:0] mem[WORD_NUMB];
  logic [MEM_WIDTH-1:0] ref_mem[WORD_NUMB];

  always #5 clk = ~clk;

  mem_arbiter_if #(.MEM_WIDTH(MEM_WIDTH), .MEM_DEPTH(MEM_DEPTH)) bus ();

  mem_arbiter #(.MEM_WIDTH(MEM_WIDTH), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mem_arbiter_chk chk (
    .clk          (clk),
    .rst          (rst),
    .req_ready    (bus.req_ready),
    .rsp_valid    (bus.rsp_valid),
    .mem_write_en (bus.mem_write_en),
    .mem_read_en  (bus.mem_read_en)
  );

  // Memory model: asynchronous read, write on the clock edge
  always_comb bus.mem_read_out = mem[bus.mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < WORD_NUMB; i++) mem[i] <= {MEM_WIDTH{1'b0}};
    end else if (bus.mem_write_en) begin
      mem[bus.mem_addr] <= bus.mem_write_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response scoreboard and enable exclusivity, every cycle
  always @(negedge clk) begin
    exp_t e;
    check("en_excl", {31'd0, bus.mem_write_en & bus.mem_read_en}, 32'd0);
    if (bus.rsp_valid !== 2'b00) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {30'd0, bus.rsp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", {30'd0, bus.rsp_valid}, {30'd0, id_to_onehot(e.id)});
        check("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, e.rdata});
        check("rsp_cycle", cyc, e.due);
      end
    end else if (sb.size() != 0 && sb[0].due < cyc) begin
      check("rsp_missing", {30'd0, bus.rsp_valid}, {30'd0, id_to_onehot(sb[0].id)});
      void'(sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] w,
                       input logic [MEM_DEPTH-1:0] a0, input logic [MEM_DEPTH-1:0] a1,
                       input logic [MEM_WIDTH-1:0] d0, input logic [MEM_WIDTH-1:0] d1);
    bus.req_valid  = v;
    bus.req_write  = w;
    bus.req_addr0  = a0;
    bus.req_addr1  = a1;
    bus.req_wdata0 = d0;
    bus.req_wdata1 = d1;
  endtask

  task automatic push_exp(input logic id, input logic wr, input logic [MEM_DEPTH-1:0] addr,
                          input logic [MEM_WIDTH-1:0] wd);
    exp_t e;
    e.id    = id;
    e.rdata = wr ? {MEM_WIDTH{1'b0}} : ref_mem[addr];
    e.due   = cyc + 2;
    sb.push_back(e);
    if (wr) ref_mem[addr] = wd;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);
  endtask

  task automatic do_txn(input vec_t v);
    logic                 id;
    logic                 wr;
    logic [MEM_DEPTH-1:0] addr;
    logic [MEM_WIDTH-1:0] wd;
    @(posedge clk); #1;
    drive(v.valid, v.write, v.a0, v.a1, v.d0, v.d1);
    @(negedge clk);
    check("ready_idle", {30'd0, bus.req_ready}, {30'd0, v.ready});
    id   = v.ready[1];
    wr   = v.write[id];
    addr = id ? v.a1 : v.a0;
    wd   = id ? v.d1 : v.d0;
    if (v.ready != 2'b00) push_exp(id, wr, addr, wd);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("ready_access", {30'd0, bus.req_ready}, 32'd0);
    if (v.ready != 2'b00) begin
      check("wr_en_access", {31'd0, bus.mem_write_en}, {31'd0, wr});
      check("rd_en_access", {31'd0, bus.mem_read_en}, {31'd0, ~wr});
      check("mem_addr_access", {30'd0, bus.mem_addr}, {30'd0, addr});
      check("mem_wdata_access", {24'd0, bus.mem_write_in}, {24'd0, wd});
      @(posedge clk); #1;
      @(negedge clk);
      check("ready_resp", {30'd0, bus.req_ready}, 32'd0);
      check("en_resp", {30'd0, bus.mem_write_en, bus.mem_read_en}, 32'd0);
      check("mem_addr_hold", {30'd0, bus.mem_addr}, {30'd0, addr});
    end else begin
      check("en_no_txn", {30'd0, bus.mem_write_en, bus.mem_read_en}, 32'd0);
    end
  endtask

  initial begin
    logic [1:0] er;
    vt[0]  = '{2'b01, 2'b01, 2'd2, 2'd0, 8'hA5, 8'h00, 2'b01};
    vt[1]  = '{2'b10, 2'b00, 2'd0, 2'd2, 8'h00, 8'h00, 2'b10};
    vt[2]  = '{2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00};
    vt[3]  = '{2'b11, 2'b00, 2'd1, 2'd3, 8'h00, 8'h00, 2'b01};
    vt[4]  = '{2'b11, 2'b11, 2'd0, 2'd3, 8'h11, 8'h3C, 2'b10};
    vt[5]  = '{2'b10, 2'b00, 2'd0, 2'd3, 8'h00, 8'h00, 2'b10};
    vt[6]  = '{2'b11, 2'b01, 2'd3, 2'd0, 8'hFF, 8'h00, 2'b01};
    vt[7]  = '{2'b01, 2'b00, 2'd3, 2'd0, 8'h00, 8'h00, 2'b01};
    vt[8]  = '{2'b11, 2'b00, 2'd0, 2'd3, 8'h00, 8'h00, 2'b10};
    vt[9]  = '{2'b11, 2'b10, 2'd2, 2'd1, 8'h00, 8'h5A, 2'b01};
    vt[10] = '{2'b11, 2'b10, 2'd2, 2'd1, 8'h00, 8'h5A, 2'b10};
    vt[11] = '{2'b01, 2'b00, 2'd1, 2'd0, 8'h00, 8'h00, 2'b01};
    for (int i = 0; i < WORD_NUMB; i++) ref_mem[i] = {MEM_WIDTH{1'b0}};

    // Reset with both requesters already valid
    rst = 1'b1;
    drive(2'b11, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {30'd0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    check("rst_en", {30'd0, bus.mem_write_en, bus.mem_read_en}, 32'd0);
    check("rst_mem_addr", {30'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, bus.mem_write_in}, 32'd0);
    check("rst_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Continuous contention: grants alternate 0,1,0,1 every third cycle
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      er = (k % 3 == 0) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      check("contend_ready", {30'd0, bus.req_ready}, {30'd0, er});
      check("contend_not_both", {31'd0, bus.req_ready == 2'b11}, 32'd0);
      if (er != 2'b00) push_exp(er[1], 1'b0, 2'd0, 8'h00);
      @(posedge clk); #1;
    end
    bus.req_valid = 2'b00;
    drain();

    for (int i = 0; i < 12; i++) do_txn(vt[i]);
    drain();

    // Only requester 1 valid: accepted every third cycle, never stalled
    @(posedge clk); #1;
    drive(2'b10, 2'b00, 2'd0, 2'd2, 8'h00, 8'h00);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      er = (k % 3 == 0) ? 2'b10 : 2'b00;
      check("solo1_ready", {30'd0, bus.req_ready}, {30'd0, er});
      if (er != 2'b00) push_exp(1'b1, 1'b0, 2'd2, 8'h00);
      @(posedge clk); #1;
    end
    bus.req_valid = 2'b00;
    drain();

    // Reset during the ACCESS cycle of a write aborts it and resets the pointer
    @(posedge clk); #1;
    drive(2'b01, 2'b01, 2'd1, 2'd0, 8'h77, 8'h00);
    @(negedge clk);
    check("abort_accept", {30'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    check("abort_access_wr", {31'd0, bus.mem_write_en}, 32'd1);
    check("abort_rst_rsp", {30'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_en", {30'd0, bus.mem_write_en, bus.mem_read_en}, 32'd0);
    check("abort_rsp", {30'd0, bus.rsp_valid}, 32'd0);
    check("abort_mem_addr", {30'd0, bus.mem_addr}, 32'd0);
    check("abort_mem_wdata", {24'd0, bus.mem_write_in}, 32'd0);
    @(negedge clk);
    check("abort_rsp_late", {30'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    drive(2'b11, 2'b00, 2'd2, 2'd3, 8'h00, 8'h00);
    @(negedge clk);
    check("abort_ptr_reset", {30'd0, bus.req_ready}, 32'd1);
    push_exp(1'b0, 1'b0, 2'd2, 8'h00);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
